flow_out_demux: RTL and testbench
=================================

Name: flow_out_demux

Overview:
- Receiving end of the tagged multi-flow write interface.
- Accepts the accelerator output stream, where each word carries a flow tag in its MSBs, and steers each word into one of FLUX per-flow show-ahead FIFOs.
- Drives per-flow full back to the producer and exposes per-flow read ports.
- Counts words per flow against a programmed block length and flags completion and protocol errors.

Parameters:
- FLUX, 4, number of flows; tag width TAG_W = $clog2(FLUX), minimum 1.
- DATA_W, 8, payload width.
- DEPTH, 16, words per flow FIFO; power of two, at least 2.
- LEN_W, 16, width of the block-length counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  TAG_W+DATA_W  {tag, payload}; tag = din[TAG_W+DATA_W-1:DATA_W].
- write  in  1  producer write strobe.
- full  out  FLUX  per-flow full to the producer; bit f = FIFO f holds DEPTH words.
- cfg_din  in  TAG_W+LEN_W  {tag, expected word count for that flow}.
- cfg_write  in  1  length programming strobe.
- read  in  FLUX  per-flow pop strobe.
- dout  out  FLUX*DATA_W  per-flow head word; slice f = [f*DATA_W +: DATA_W].
- empty  out  FLUX  per-flow empty.
- done  out  FLUX  sticky; flow f received exactly its programmed length.
- err_ovf  out  FLUX  sticky; a write to flow f was dropped because full[f] was set.
- err_len  out  FLUX  sticky; flow f accepted a word after done[f] was set.

Behaviour:
- Reset (rst=0, asynchronous): all FIFO pointers and counts, rx_cnt, len, done, err_ovf and err_len go to 0. Consequently full=0 and empty=all ones. dout is don't-care while empty.
  - Reset asserted mid-block discards all FIFO contents and configuration.
  - Release is sampled synchronously at the next clk edge.
- full[f] and empty[f] are decoded from registered per-flow counts only, with no combinational path from write or read.
- Write acceptance: a word is accepted for flow f when write=1, tag=f and full[f]=0, as sampled at the clock edge. It is stored at the FIFO tail, and rx_cnt[f] increments.
  - Accepted write into an empty FIFO: empty[f] deasserts the next cycle, so write-to-dout latency is 1 cycle.
  - The producer may write every cycle, with tags interleaved arbitrarily.
- Dropped write: write=1, tag=f and full[f]=1 -> word discarded, rx_cnt unchanged, err_ovf[f] set.
  - A read in the same cycle does not rescue the write; full is evaluated pre-edge.
- Out-of-range tag (tag >= FLUX, only possible when FLUX is not a power of two): word discarded, no flag.
- Read: read[f]=1 with empty[f]=0 pops the head at the edge, and dout[f] shows the next word the same cycle after the edge (show-ahead). read[f] while empty[f]=1 is ignored.
- Simultaneous read and write on the same flow:
  - Non-empty and non-full: count unchanged, both take effect.
  - Empty: the write is accepted and the read is ignored.
  - Full: the write is dropped and the read pops.
- Flows are fully independent; read and write activity on one flow never stalls another.
- Length programming: cfg_write=1 loads len[f] := cfg_din[LEN_W-1:0] for f = cfg tag, and clears rx_cnt[f], done[f] and err_len[f]. FIFO f contents are kept.
  - If cfg_write and an accepted write for the same flow coincide, cfg wins: rx_cnt[f] becomes 0 and the word is still stored in the FIFO.
- len[f]=0 means unbounded: done[f] never sets and err_len[f] never sets.
- Completion: when an accepted write makes rx_cnt[f] equal len[f] (len nonzero), done[f] rises the following cycle and holds until the next cfg_write to f or reset.
- Further accepted writes to flow f while done[f]=1 are still stored and counted, and set err_len[f].
- rx_cnt saturates at 2^LEN_W-1.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy counts are log2(DEPTH)+1 bits.

Test Plan:
- Reset/idle: hold rst=0 for 5 cycles, then release -> full=4'b0000, empty=4'b1111, done=0, err_ovf=0, err_len=0; read pulses on empty flows change nothing.
- Interleave: program len = 9,9,9,9; write tags 0,1,2,3 round-robin with payload = index, 36 words total, while reading every flow continuously -> each flow yields 0..8 in order, done=4'b1111 one cycle after the 36th accepted word, no errors.
- Backpressure: DEPTH=16 with no reads; write 17 words to flow 2 -> full[2] asserts after the 16th accepted word, the 17th is dropped, err_ovf=4'b0100, the other flows' full bits stay 0; one read frees a slot, full[2]=0 next cycle, and a write in that cycle is accepted.
- Wrap-around: push and pop 40 words through flow 1 with occupancy between 1 and 16 -> output order and values identical to input, pointers wrap without loss.
- Length boundary: len[3]=5; send 6 words on flow 3 -> done[3] rises after the 5th word, err_len[3] sets on the 6th, and the 6th word is still readable; a cfg_write to flow 3 clears done[3] and err_len[3].
- Mid-stream reset: assert rst with 7 words queued in flow 0 and done[1]=1 -> outputs return to reset values immediately (asynchronously), and no stale word appears on dout[0] after release.

Source files
------------

// File: rtl/flow_out_demux_if.sv
// flow_out_demux_if: bundle of the tagged write stream, the length programming
// port and the per-flow read side of flow_out_demux.
//   master : producer/consumer side (drives din/write/cfg/read)
//   slave  : demux side (drives full/dout/empty/done/err_*)
// Signals:
//   din       {tag, payload} write word      write     write strobe
//   full      per-flow full                  cfg_din   {tag, block length}
//   cfg_write length programming strobe      read      per-flow pop strobe
//   dout      per-flow head words (flat)     empty     per-flow empty
//   done      per-flow block complete        err_ovf   per-flow dropped write
//   err_len   per-flow write after done
interface flow_out_demux_if #(
    parameter int FLUX   = 4,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
);
    localparam int TAG_W = (FLUX > 1) ? $clog2(FLUX) : 1;

    logic [TAG_W+DATA_W-1:0] din;
    logic                    write;
    logic [FLUX-1:0]         full;
    logic [TAG_W+LEN_W-1:0]  cfg_din;
    logic                    cfg_write;
    logic [FLUX-1:0]         read;
    logic [FLUX*DATA_W-1:0]  dout;
    logic [FLUX-1:0]         empty;
    logic [FLUX-1:0]         done;
    logic [FLUX-1:0]         err_ovf;
    logic [FLUX-1:0]         err_len;

    modport master (
        output din, write, cfg_din, cfg_write, read,
        input  full, dout, empty, done, err_ovf, err_len
    );

    modport slave (
        input  din, write, cfg_din, cfg_write, read,
        output full, dout, empty, done, err_ovf, err_len
    );
endinterface

// File: rtl/flow_out_demux.sv
// flow_out_demux: receiving end of the tagged multi-flow write interface.
// Each incoming word carries a flow tag in its MSBs and is steered into one of
// FLUX show-ahead FIFOs. Per flow, accepted words are counted against a
// programmed block length to flag completion and length/overflow errors.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  flow_out_demux_if.slave (write stream, cfg, per-flow read side)

// One flow: FIFO, word counter and sticky status flags.
module flow_out_demux_lane #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_hit,   // write strobe with tag == this flow
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic              cfg_hit,  // cfg strobe with tag == this flow
    input  logic [LEN_W-1:0]  cfg_len,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic              done,
    output logic              err_ovf,
    output logic              err_len
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              done_q, done_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_len_q, err_len_d;

    logic              wr_acc;
    logic              rd_acc;
    logic [LEN_W-1:0]  rx_inc;

    // Status comes only from the registered count: no write/read -> full path.
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

    assign wr_acc = wr_hit && !full;
    assign rd_acc = rd_req && !empty;

    // Show-ahead: the head word is visible without a read.
    assign head    = mem_q[rptr_q];
    assign done    = done_q;
    assign err_ovf = err_ovf_q;
    assign err_len = err_len_q;

    // Saturating increment of the received-word counter.
    assign rx_inc = (rx_cnt_q == '1) ? rx_cnt_q : rx_cnt_q + LEN_W'(1);

    always_comb begin
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        rx_cnt_d  = rx_cnt_q;
        len_d     = len_q;
        done_d    = done_q;
        err_ovf_d = err_ovf_q;
        err_len_d = err_len_q;

        if (wr_acc) begin
            mem_d[wptr_q] = wr_data;
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // Dropped writes are flagged regardless of cfg activity.
        if (wr_hit && full) begin
            err_ovf_d = 1'b1;
        end

        // Programming restarts the block; it overrides a coincident write's
        // effect on the counter, but the word itself is still stored above.
        if (cfg_hit) begin
            len_d     = cfg_len;
            rx_cnt_d  = '0;
            done_d    = 1'b0;
            err_len_d = 1'b0;
        end else if (wr_acc) begin
            rx_cnt_d = rx_inc;
            if (done_q) begin
                err_len_d = 1'b1;
            end
            // len == 0 is unbounded, so completion never fires.
            if ((len_q != '0) && (rx_inc == len_q)) begin
                done_d = 1'b1;
            end
        end
    end

    // Storage has no reset; contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            rx_cnt_q  <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            err_ovf_q <= 1'b0;
            err_len_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            len_q     <= len_d;
            done_q    <= done_d;
            err_ovf_q <= err_ovf_d;
            err_len_q <= err_len_d;
        end
    end
endmodule

module flow_out_demux #(
    parameter int FLUX   = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    flow_out_demux_if.slave bus
);
    localparam int TAG_W = (FLUX > 1) ? $clog2(FLUX) : 1;

    logic [TAG_W-1:0]             wr_tag;
    logic [DATA_W-1:0]            wr_data;
    logic [TAG_W-1:0]             cfg_tag;
    logic [LEN_W-1:0]             cfg_len;

    logic [FLUX-1:0][DATA_W-1:0]  head;
    logic [FLUX-1:0]              full;
    logic [FLUX-1:0]              empty;
    logic [FLUX-1:0]              done;
    logic [FLUX-1:0]              err_ovf;
    logic [FLUX-1:0]              err_len;

    assign wr_tag  = bus.din[TAG_W+DATA_W-1:DATA_W];
    assign wr_data = bus.din[DATA_W-1:0];
    assign cfg_tag = bus.cfg_din[TAG_W+LEN_W-1:LEN_W];
    assign cfg_len = bus.cfg_din[LEN_W-1:0];

    // Tags >= FLUX match no lane, so such words vanish without a flag.
    for (genvar f = 0; f < FLUX; f++) begin : g_lane
        flow_out_demux_lane #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .LEN_W  (LEN_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .wr_hit  (bus.write && (wr_tag == TAG_W'(f))),
            .wr_data (wr_data),
            .rd_req  (bus.read[f]),
            .cfg_hit (bus.cfg_write && (cfg_tag == TAG_W'(f))),
            .cfg_len (cfg_len),
            .head    (head[f]),
            .full    (full[f]),
            .empty   (empty[f]),
            .done    (done[f]),
            .err_ovf (err_ovf[f]),
            .err_len (err_len[f])
        );
    end

    assign bus.dout    = head;
    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.done    = done;
    assign bus.err_ovf = err_ovf;
    assign bus.err_len = err_len;
endmodule

// File: tb/tb_flow_out_demux.sv
// Bench for flow_out_demux: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based per-flow reference model.
module tb_flow_out_demux;
    localparam int FLUX   = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LEN_W  = 16;
    localparam int TAG_W  = 2;
    localparam int RX_MAX = (1 << LEN_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    flow_out_demux_if #(.FLUX(FLUX), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    flow_out_demux #(
        .FLUX(FLUX), .DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one queue per flow plus counters and sticky flags.
    int              q [FLUX][$];
    int              m_rx  [FLUX];
    int              m_len [FLUX];
    logic [FLUX-1:0] m_done, m_ovf, m_elen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int f = 0; f < FLUX; f++) begin
            q[f].delete();
            m_rx[f]  = 0;
            m_len[f] = 0;
        end
        m_done = '0;
        m_ovf  = '0;
        m_elen = '0;
    endtask

    task automatic model_step(input bit w, input int tg, input int pl,
                              input logic [FLUX-1:0] rd, input bit cw,
                              input int ctg, input int clen);
        for (int f = 0; f < FLUX; f++) begin
            bit wr, fl, em, acc;
            wr  = w && (tg == f);
            fl  = (q[f].size() == DEPTH);
            em  = (q[f].size() == 0);
            acc = wr && !fl;
            if (wr && fl) m_ovf[f] = 1'b1;
            if (rd[f] && !em) void'(q[f].pop_front());
            if (acc) q[f].push_back(pl & 8'hFF);
            if (cw && (ctg == f)) begin
                m_len[f]  = clen;
                m_rx[f]   = 0;
                m_done[f] = 1'b0;
                m_elen[f] = 1'b0;
            end else if (acc) begin
                if (m_done[f]) m_elen[f] = 1'b1;
                if (m_rx[f] < RX_MAX) m_rx[f]++;
                if ((m_len[f] != 0) && (m_rx[f] == m_len[f])) m_done[f] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [FLUX-1:0] ef, ee;
        for (int f = 0; f < FLUX; f++) begin
            ef[f] = (q[f].size() == DEPTH);
            ee[f] = (q[f].size() == 0);
        end
        chk("full", bus.full, ef);
        chk("empty", bus.empty, ee);
        chk("done", bus.done, m_done);
        chk("err_ovf", bus.err_ovf, m_ovf);
        chk("err_len", bus.err_len, m_elen);
        for (int f = 0; f < FLUX; f++) begin
            if (q[f].size() != 0) chk($sformatf("dout%0d", f), bus.dout[f*DATA_W +: DATA_W], q[f][0]);
        end
    endtask

    task automatic idle_inputs();
        bus.write     = 1'b0;
        bus.din       = '0;
        bus.read      = '0;
        bus.cfg_write = 1'b0;
        bus.cfg_din   = '0;
    endtask

    // One clock: drive at the falling edge, model at the rising edge, check
    // at the next falling edge.
    task automatic cyc(input bit w, input int tg, input int pl,
                       input logic [FLUX-1:0] rd, input bit cw,
                       input int ctg, input int clen);
        logic [TAG_W-1:0]  t, ct;
        logic [DATA_W-1:0] p;
        logic [LEN_W-1:0]  l;
        t  = tg[TAG_W-1:0];
        ct = ctg[TAG_W-1:0];
        p  = pl[DATA_W-1:0];
        l  = clen[LEN_W-1:0];
        bus.write     = w;
        bus.din       = {t, p};
        bus.read      = rd;
        bus.cfg_write = cw;
        bus.cfg_din   = {ct, l};
        @(posedge clk);
        model_step(w, tg, pl, rd, cw, ctg, clen);
        @(negedge clk);
        idle_inputs();
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #1;
        model_clear();
        check_all();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        idle_inputs();
        model_clear();

        // Reset / idle, reads on empty flows are ignored.
        do_reset();
        chk("rst_full", bus.full, 4'b0000);
        chk("rst_empty", bus.empty, 4'b1111);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4'hF, 0, 0, 0);
        chk("idle_empty", bus.empty, 4'b1111);

        // Interleaved round-robin with continuous reads.
        do_reset();
        for (int f = 0; f < FLUX; f++) cyc(0, 0, 0, 4'h0, 1, f, 9);
        for (int i = 0; i < 36; i++) cyc(1, i % 4, i / 4, 4'hF, 0, 0, 0);
        chk("ilv_done", bus.done, 4'b1111);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4'hF, 0, 0, 0);
        chk("ilv_drained", bus.empty, 4'b1111);
        chk("ilv_errs", {bus.err_ovf, bus.err_len}, 8'h00);

        // Backpressure on flow 2.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cyc(1, 2, i, 4'h0, 0, 0, 0);
            if (i == 15) chk("bp_full16", bus.full, 4'b0100);
        end
        chk("bp_ovf", bus.err_ovf, 4'b0100);
        cyc(0, 0, 0, 4'b0100, 0, 0, 0);
        chk("bp_freed", bus.full, 4'b0000);
        cyc(1, 2, 8'hA5, 4'h0, 0, 0, 0);
        chk("bp_refull", bus.full, 4'b0100);

        // Wrap-around on flow 1.
        do_reset();
        for (int i = 0; i < 15; i++) cyc(1, 1, i, 4'h0, 0, 0, 0);
        for (int i = 15; i < 40; i++) cyc(1, 1, i, 4'b0010, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 4'b0010, 0, 0, 0);
        chk("wrap_empty", bus.empty, 4'b1111);

        // Length boundary on flow 3.
        do_reset();
        cyc(0, 0, 0, 4'h0, 1, 3, 5);
        for (int i = 0; i < 5; i++) cyc(1, 3, 16 + i, 4'h0, 0, 0, 0);
        chk("len_done", bus.done, 4'b1000);
        chk("len_noerr", bus.err_len, 4'b0000);
        cyc(1, 3, 21, 4'h0, 0, 0, 0);
        chk("len_err", bus.err_len, 4'b1000);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 4'b1000, 0, 0, 0);
        chk("len_6th", bus.dout[3*DATA_W +: DATA_W], 8'd21);
        cyc(0, 0, 0, 4'b1000, 1, 3, 5);
        chk("len_cfg_clr", {bus.done, bus.err_len}, 8'h00);

        // Coincident cfg and write: counter restarts, word still stored.
        cyc(1, 0, 7, 4'h0, 1, 0, 2);
        cyc(1, 0, 8, 4'h0, 0, 0, 0);
        chk("cfgwr_notdone", bus.done, 4'b0000);
        cyc(1, 0, 9, 4'h0, 0, 0, 0);
        chk("cfgwr_done", bus.done, 4'b0001);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [FLUX-1:0] rd;
            for (int f = 0; f < FLUX; f++) rd[f] = ($urandom_range(9) < 4);
            cyc($urandom_range(3) != 0, $urandom_range(FLUX - 1), $urandom_range(255), rd,
                $urandom_range(19) == 0, $urandom_range(FLUX - 1), $urandom_range(12));
        end

        // Mid-stream asynchronous reset.
        do_reset();
        cyc(0, 0, 0, 4'h0, 1, 1, 1);
        cyc(1, 1, 3, 4'h0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 0, 100 + i, 4'h0, 0, 0, 0);
        chk("mid_done1", bus.done, 4'b0010);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        check_all();
        chk("mid_async_empty", bus.empty, 4'b1111);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 4'h0, 0, 0, 0);
        chk("mid_stale", bus.empty[0], 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
